// File: rtl/reset_seq.sv
// Staggered reset sequencer: PLL-lock hold-off, per-domain release order, re-entry on lock loss/sw request.
// Latency: first release HOLD_CYCLES+2 edges after reset drops; channels STAGE_GAP apart; sw re-entry 1 edge.
module reset_seq #(
   parameter int CHANNELS    = 3,
   parameter int HOLD_CYCLES = 255,
   parameter int STAGE_GAP   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pll_lock,
   input  logic                sw_rst_req,
   output logic [CHANNELS-1:0] rst_out,
   output logic                ready,
   output logic [1:0]          cause
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int GW = $clog2(STAGE_GAP + 1);
   localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [HW-1:0]       HOLD_TERM = HW'(HOLD_CYCLES - 1);
   localparam logic [GW-1:0]       GAP_TERM  = GW'(STAGE_GAP - 1);
   localparam logic [IW-1:0]       LAST_IDX  = IW'(CHANNELS - 1);
   localparam logic [CHANNELS-1:0] ONE       = CHANNELS'(1);

   localparam logic [1:0] CAUSE_EXT  = 2'b00;
   localparam logic [1:0] CAUSE_LOCK = 2'b01;
   localparam logic [1:0] CAUSE_SW   = 2'b10;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      STAGGER = 2'd1,
      RUN     = 2'd2
   } state_t;

   state_t                  state;
   logic [HW-1:0]           hold_cnt;
   logic [GW-1:0]           gap_cnt;
   logic [IW-1:0]           idx;
   logic [1:0]              rst_pipe;
   logic                    rst_sync;
   logic [SYNC_STAGES-1:0]  lock_pipe;
   logic                    lock_sync;

   // Release of the master reset is synchronised; assertion stays asynchronous.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rst_pipe <= 2'b11;
      else       rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst_sync = rst_pipe[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lock_pipe <= '0;
      else       lock_pipe <= {lock_pipe[SYNC_STAGES-2:0], pll_lock};
   end
   assign lock_sync = lock_pipe[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= HOLD;
         hold_cnt <= '0;
         gap_cnt  <= '0;
         idx      <= '0;
         rst_out  <= '1;
         ready    <= 1'b0;
         cause    <= CAUSE_EXT;
      end else if (rst_sync) begin
         state    <= HOLD;
         hold_cnt <= '0;
         gap_cnt  <= '0;
         idx      <= '0;
         rst_out  <= '1;
         ready    <= 1'b0;
         cause    <= CAUSE_EXT;
      end else begin
         case (state)
            HOLD: begin
               if (!lock_sync) begin
                  hold_cnt <= '0;
               end else if (hold_cnt == HOLD_TERM) begin
                  rst_out  <= rst_out & ~ONE;
                  hold_cnt <= '0;
                  gap_cnt  <= '0;
                  if (CHANNELS == 1) begin
                     ready <= 1'b1;
                     state <= RUN;
                  end else begin
                     idx   <= IW'(1);
                     state <= STAGGER;
                  end
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            STAGGER, RUN: begin
               // Lock loss takes priority over a simultaneous software request.
               if (!lock_sync || sw_rst_req) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
                  gap_cnt  <= '0;
                  idx      <= '0;
                  rst_out  <= '1;
                  ready    <= 1'b0;
                  cause    <= !lock_sync ? CAUSE_LOCK : CAUSE_SW;
               end else if (state == STAGGER) begin
                  if (gap_cnt == GAP_TERM) begin
                     rst_out <= rst_out & ~(ONE << idx);
                     gap_cnt <= '0;
                     if (idx == LAST_IDX) begin
                        ready <= 1'b1;
                        state <= RUN;
                     end else begin
                        idx <= idx + IW'(1);
                     end
                  end else begin
                     gap_cnt <= gap_cnt + GW'(1);
                  end
               end
            end
            default: state <= HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: default instance plus a CHANNELS=1, HOLD_CYCLES=1 instance.
module tb_reset_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       pll_lock;
   logic       sw_rst_req;
   logic [2:0] rst_out;
   logic       ready;
   logic [1:0] cause;

   logic       reset1;
   logic       lock1;
   logic       sw1;
   logic [0:0] rst_out1;
   logic       ready1;
   logic [1:0] cause1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reset_seq dut (
      .clk        (clk),
      .reset      (reset),
      .pll_lock   (pll_lock),
      .sw_rst_req (sw_rst_req),
      .rst_out    (rst_out),
      .ready      (ready),
      .cause      (cause)
   );

   reset_seq #(.CHANNELS(1), .HOLD_CYCLES(1), .STAGE_GAP(16), .SYNC_STAGES(2)) dut1 (
      .clk        (clk),
      .reset      (reset1),
      .pll_lock   (lock1),
      .sw_rst_req (sw1),
      .rst_out    (rst_out1),
      .ready      (ready1),
      .cause      (cause1)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; reset1 = 1'b1;
      pll_lock = 1'b1; lock1 = 1'b1;
      sw_rst_req = 1'b0; sw1 = 1'b0;
      tick(3);
      total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL reset_rst_out got=%b want=111", rst_out); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
      total++; if (cause !== 2'b00) begin bad++; $display("FAIL reset_cause got=%b want=00", cause); end
      total++; if (rst_out1 !== 1'b1) begin bad++; $display("FAIL reset_rst_out1 got=%b want=1", rst_out1); end
      total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%b want=0", ready1); end
   endtask

   task automatic test_single();
      reset1 = 1'b0;
      tick(2);
      total++; if (rst_out1 !== 1'b1) begin bad++; $display("FAIL single_e2_rst got=%b want=1", rst_out1); end
      total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL single_e2_ready got=%b want=0", ready1); end
      tick(1);
      total++; if (rst_out1 !== 1'b0) begin bad++; $display("FAIL single_e3_rst got=%b want=0", rst_out1); end
      total++; if (ready1 !== 1'b1) begin bad++; $display("FAIL single_e3_ready got=%b want=1", ready1); end
      total++; if (cause1 !== 2'b00) begin bad++; $display("FAIL single_cause got=%b want=00", cause1); end
   endtask

   task automatic test_powerup();
      reset = 1'b0;
      tick(256);
      total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL pu_e256 got=%b want=111", rst_out); end
      tick(1);
      total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL pu_e257 got=%b want=110", rst_out); end
      tick(15);
      total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL pu_e272 got=%b want=110", rst_out); end
      tick(1);
      total++; if (rst_out !== 3'b100) begin bad++; $display("FAIL pu_e273 got=%b want=100", rst_out); end
      tick(15);
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL pu_e288_ready got=%b want=0", ready); end
      tick(1);
      total++; if (rst_out !== 3'b000) begin bad++; $display("FAIL pu_e289 got=%b want=000", rst_out); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL pu_e289_ready got=%b want=1", ready); end
      total++; if (cause !== 2'b00) begin bad++; $display("FAIL pu_cause got=%b want=00", cause); end
   endtask

   task automatic test_lock_loss();
      pll_lock = 1'b0;
      tick(2);
      total++; if (rst_out !== 3'b000) begin bad++; $display("FAIL ll_n1 got=%b want=000", rst_out); end
      tick(1);
      total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL ll_n2 got=%b want=111", rst_out); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL ll_ready got=%b want=0", ready); end
      total++; if (cause !== 2'b01) begin bad++; $display("FAIL ll_cause got=%b want=01", cause); end
      pll_lock = 1'b1;
      tick(256);
      total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL ll_m256 got=%b want=111", rst_out); end
      tick(1);
      total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL ll_m257 got=%b want=110", rst_out); end
      tick(32);
      total++; if (rst_out !== 3'b000) begin bad++; $display("FAIL ll_run got=%b want=000", rst_out); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL ll_run_ready got=%b want=1", ready); end
      total++; if (cause !== 2'b01) begin bad++; $display("FAIL ll_cause_persist got=%b want=01", cause); end
   endtask

   task automatic test_sw_req();
      sw_rst_req = 1'b1;
      tick(1);
      sw_rst_req = 1'b0;
      total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL sw_rst got=%b want=111", rst_out); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL sw_ready got=%b want=0", ready); end
      total++; if (cause !== 2'b10) begin bad++; $display("FAIL sw_cause got=%b want=10", cause); end
      tick(254);
      total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL sw_n254 got=%b want=111", rst_out); end
      tick(1);
      total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL sw_n255 got=%b want=110", rst_out); end
   endtask

   task automatic test_both();
      pll_lock = 1'b0;
      tick(2);
      total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL both_pre got=%b want=110", rst_out); end
      sw_rst_req = 1'b1;
      tick(1);
      sw_rst_req = 1'b0;
      pll_lock = 1'b1;
      total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL both_rst got=%b want=111", rst_out); end
      total++; if (cause !== 2'b01) begin bad++; $display("FAIL both_cause got=%b want=01", cause); end
   endtask

   task automatic test_async_reset();
      tick(257);
      total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL ar_stagger got=%b want=110", rst_out); end
      tick(3);
      #3;
      reset = 1'b1;
      #1;
      total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL ar_rst got=%b want=111", rst_out); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL ar_ready got=%b want=0", ready); end
      total++; if (cause !== 2'b00) begin bad++; $display("FAIL ar_cause got=%b want=00", cause); end
   endtask

   task automatic test_late_lock();
      pll_lock = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(100);
      total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL late_nolock got=%b want=111", rst_out); end
      pll_lock = 1'b1;
      tick(50);
      pll_lock = 1'b0;
      tick(5);
      pll_lock = 1'b1;
      tick(202);
      total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL late_noglitch_time got=%b want=111", rst_out); end
      tick(54);
      total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL late_p311 got=%b want=111", rst_out); end
      tick(1);
      total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL late_p312 got=%b want=110", rst_out); end
      total++; if (cause !== 2'b00) begin bad++; $display("FAIL late_cause got=%b want=00", cause); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_powerup();
      test_lock_loss();
      test_sw_req();
      test_both();
      test_async_reset();
      test_late_lock();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reset_seq.md
# reset_seq

Parametrised power-on/reset sequencer for the up5k designs. It replaces the fixed 8-bit reset counter in the top level with a block that gates release on PLL lock and applies a programmable hold time. Resets for multiple downstream domains (CPU, video, peripherals) are released in a staggered order. It re-enters reset on PLL lock loss or a software request, and records the cause of the last reset.

## Interface
- CHANNELS, 3: number of reset outputs, 1..8; released in index order 0 first.
- HOLD_CYCLES, 255: clocks of continuous lock required before first release, ≥1.
- STAGE_GAP, 16: clocks between successive channel releases, ≥1.
- SYNC_STAGES, 2: flops in pll_lock synchroniser, ≥2.

- clk  in  1  system clock (PLL output).
- reset  in  1  asynchronous, active-high master reset.
- pll_lock  in  1  PLL LOCK, asynchronous to clk.
- sw_rst_req  in  1  synchronous software/watchdog reset request, sampled each edge.
- rst_out  out  CHANNELS  active-high per-domain resets.
- ready  out  1  high when all channels released.
- cause  out  2  last reset cause: 00 external, 01 lock loss, 10 software.

## Operation
- Reset release synchroniser: 2 flops, asynchronously set by reset, shifting in 0. Internal rst_sync = last flop. FSM, counters and outputs are asynchronously forced to reset values while reset=1 and held there while rst_sync=1.
- Reset values: rst_out all ones, ready 0, cause 00, state HOLD, hold counter 0, gap counter 0, channel index 0.
- pll_lock passes through SYNC_STAGES flops, reset to 0, giving lock_sync.
- States:
  - HOLD
    - Each edge with lock_sync=1: hold counter +1.
    - lock_sync=0: hold counter cleared.
    - Edge where counter==HOLD_CYCLES-1 and lock_sync=1: clear rst_out[0], zero the gap counter, set index=1, go to STAGGER. If CHANNELS==1, go to RUN and set ready=1 instead.
    - sw_rst_req ignored.
  - STAGGER
    - Gap counter +1 each edge.
    - Edge where gap==STAGE_GAP-1: clear rst_out[index], index+1, gap counter 0.
    - Clearing rst_out[CHANNELS-1] also sets ready=1 and moves to RUN on the same edge.
  - RUN: steady state, no counting.
- Re-entry, from STAGGER or RUN only, evaluated at each edge:
  - lock_sync=0: set all rst_out, ready=0, cause=01, go to HOLD, counters and index cleared.
  - Else sw_rst_req=1: same action with cause=10.
  - Both conditions on one edge: lock loss wins, cause=01.
- cause is only written on re-entry or external reset. It persists through the following sequence and RUN.
- Counter widths: hold counter is clog2(HOLD_CYCLES+1) bits; gap counter is clog2(STAGE_GAP+1) bits. Counters never wrap in HOLD because the transition fires at terminal count.
- rst_out bits, once cleared, stay cleared until re-entry or reset. Cleared bits form a contiguous low range at all times.

## Timing
- reset rising: all outputs reach reset values asynchronously, no clock needed.
- reset falling, with lock_sync already 1:
  - Edge 1 and edge 2 after release clear the synchroniser.
  - First counting edge is edge 3.
  - rst_out[0] falls at edge HOLD_CYCLES+2.
  - rst_out[k] falls STAGE_GAP·k edges later.
  - ready rises with rst_out[CHANNELS-1].
- pll_lock latency is SYNC_STAGES edges to lock_sync. Lock loss in RUN asserts rst_out at edge SYNC_STAGES+1 after pll_lock falls (setup met).
- sw_rst_req high at edge n: rst_out all high and ready low after edge n (one-cycle latency). The full sequence then restarts from HOLD, and rst_out[0] falls HOLD_CYCLES edges after re-entry if lock is steady.
- A glitch of pll_lock shorter than one clock may be missed. Any low sample reaching lock_sync restarts the hold count.
- Mid-sequence reset assertion aborts immediately, asynchronously.

## Test plan
All scenarios use defaults (CHANNELS=3, HOLD_CYCLES=255, STAGE_GAP=16, SYNC_STAGES=2) unless noted.
- Power-up, pll_lock high throughout, reset released at edge 0 -> rst_out[0] falls edge 257, rst_out[1] edge 273, rst_out[2] and ready edge 289, cause=00.
- pll_lock rises 100 edges after reset release -> rst_out[0] falls 255+2 edges after pll_lock rises. Drop pll_lock for 5 cycles during HOLD -> count restarts, release delayed accordingly.
- In RUN, pll_lock falls before edge n -> rst_out=3'b111, ready=0 after edge n+2, cause=01. Re-release rst_out[0] 255 edges after lock_sync returns high.
- In RUN, one-cycle sw_rst_req -> all resets asserted next edge, cause=10. In STAGGER with rst_out=3'b110, sw_rst_req plus lock loss on the same edge -> cause=01.
- Assert reset asynchronously mid-STAGGER (between clock edges) -> rst_out=3'b111, ready=0, cause=00 immediately, without waiting for an edge.
- CHANNELS=1, HOLD_CYCLES=1 -> rst_out and ready toggle together at edge 3 after reset release.
